// File: rtl/r2_cutoff_filter_buffer_pkg.sv
// Shared constants and the r2 acceptance rule for the cutoff filter buffer.
package r2_cutoff_filter_buffer_pkg;

   // IEEE-754 single-precision field layout
   localparam int         FP_SIGN_BIT     = 31;
   localparam int         FP_EXP_MSB      = 30;
   localparam int         FP_EXP_LSB      = 23;
   localparam logic [7:0] FP_EXP_ALL_ONES = 8'hFF;

   // 18.0f; pairs must be strictly inside this radius squared
   localparam logic [31:0] DEFAULT_CUTOFF_2 = 32'h41900000;

   // Reserve enough free entries for everything already in flight upstream
   localparam int UPSTREAM_LATENCY = 17;
   localparam int INTERNAL_LATENCY = 2;
   localparam int SLACK_MARGIN     = 1;
   localparam int DEFAULT_SLACK    = UPSTREAM_LATENCY + INTERNAL_LATENCY + SLACK_MARGIN;

   // Non-negative floats order like unsigned integers on their magnitude bits,
   // so the cutoff test is an integer compare once sign/NaN/Inf/zero are excluded.
   function automatic logic r2_passes(input logic [31:0] r2, input logic [31:0] cutoff);
      return (r2[FP_SIGN_BIT] == 1'b0) &&
             (r2[FP_EXP_MSB:FP_EXP_LSB] != FP_EXP_ALL_ONES) &&
             (r2[30:0] != 31'd0) &&
             (r2[30:0] < cutoff[30:0]);
   endfunction

endpackage

// File: rtl/r2_cutoff_filter_buffer_if.sv
// Pair input stream and drained output stream of the cutoff filter buffer.
interface r2_cutoff_filter_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 16
);
   import r2_cutoff_filter_buffer_pkg::*;

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_r2;
   logic [DATA_WIDTH-1:0] in_dx;
   logic [DATA_WIDTH-1:0] in_dy;
   logic [DATA_WIDTH-1:0] in_dz;
   logic [TAG_WIDTH-1:0]  in_tag;
   logic                  almost_full;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_r2;
   logic [DATA_WIDTH-1:0] out_dx;
   logic [DATA_WIDTH-1:0] out_dy;
   logic [DATA_WIDTH-1:0] out_dz;
   logic [TAG_WIDTH-1:0]  out_tag;

   // Upstream producer plus downstream consumer side
   modport master (
      output in_valid, in_r2, in_dx, in_dy, in_dz, in_tag, out_ready,
      input  almost_full, out_valid, out_r2, out_dx, out_dy, out_dz, out_tag
   );

   // The buffer itself
   modport slave (
      input  in_valid, in_r2, in_dx, in_dy, in_dz, in_tag, out_ready,
      output almost_full, out_valid, out_r2, out_dx, out_dy, out_dz, out_tag
   );
endinterface

// File: rtl/r2_cutoff_filter_buffer_fifo.sv
// Show-ahead synchronous FIFO with a registered head: dout/!empty describe the
// oldest entry, and a write into an empty FIFO shows up one cycle later.
module sync_fifo_showahead
   import r2_cutoff_filter_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             head_valid_r;
   logic [WIDTH-1:0] head_r;

   logic             pop_s;
   logic             push_s;
   logic             full_s;
   logic [AW:0]      avail_s;
   logic [AW-1:0]    rd_ptr_next_s;

   // Pop only a visible head; a write while full is allowed only alongside a pop
   always_comb begin
      full_s        = (count_r == FULL_COUNT);
      pop_s         = rd_en && head_valid_r;
      push_s        = wr_en && (!full_s || pop_s);
      avail_s       = count_r - (AW+1)'(pop_s);
      rd_ptr_next_s = rd_ptr_r + AW'(pop_s);
   end

   // Storage array; written at the tail
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_r + AW'(push_s);
         rd_ptr_r <= rd_ptr_next_s;
         count_r  <= count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
      end
   end

   // Head register: only entries stored before this edge are eligible (no bypass)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_valid_r <= 1'b0;
         head_r       <= {WIDTH{1'b0}};
      end else begin
         head_valid_r <= (avail_s != {(AW+1){1'b0}});
         head_r       <= (avail_s != {(AW+1){1'b0}}) ? mem[rd_ptr_next_s] : {WIDTH{1'b0}};
      end
   end

   assign dout  = head_r;
   assign empty = !head_valid_r;
   assign full  = full_s;
   assign count = count_r;

endmodule

// File: rtl/r2_cutoff_filter_buffer.sv
// Cutoff filter: rejects out-of-range/self/invalid r2 pairs and queues the
// rest for the force stage, warning upstream early since it cannot stall.
module r2_cutoff_filter_buffer
   import r2_cutoff_filter_buffer_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          TAG_WIDTH  = 16,
   parameter logic [31:0] CUTOFF_2   = DEFAULT_CUTOFF_2,
   parameter int          FIFO_DEPTH = 32,
   parameter int          SLACK      = DEFAULT_SLACK
) (
   input  logic                     clk,
   input  logic                     rst,
   r2_cutoff_filter_buffer_if.slave bus,
   output logic [31:0]              pass_count,
   output logic [31:0]              drop_count,
   output logic                     overflow
);
   localparam int             EW       = 4*DATA_WIDTH + TAG_WIDTH;
   localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]  AF_LEVEL = CW'(FIFO_DEPTH - SLACK);

   logic          st1_valid_r;
   logic          st1_pass_r;
   logic [EW-1:0] st1_entry_r;
   logic [31:0]   pass_count_r;
   logic [31:0]   drop_count_r;
   logic          overflow_r;
   logic          almost_full_r;

   logic          pop_s;
   logic          wr_req_s;
   logic          wr_ok_s;
   logic          lost_s;
   logic [CW-1:0] occ_next_s;
   logic [EW-1:0] fifo_dout_s;
   logic          fifo_empty_s;
   logic          fifo_full_s;
   logic [CW-1:0] fifo_count_s;

   // Stage 1: capture the pair and decide pass/drop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st1_valid_r <= 1'b0;
         st1_pass_r  <= 1'b0;
         st1_entry_r <= {EW{1'b0}};
      end else begin
         st1_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            st1_pass_r  <= r2_passes(bus.in_r2, CUTOFF_2);
            st1_entry_r <= {bus.in_r2, bus.in_dx, bus.in_dy, bus.in_dz, bus.in_tag};
         end else begin
            st1_pass_r  <= st1_pass_r;
            st1_entry_r <= st1_entry_r;
         end
      end
   end

   // Stage 2 write decision; a full FIFO still takes a pair if the head leaves now
   always_comb begin
      pop_s      = !fifo_empty_s && bus.out_ready;
      wr_req_s   = st1_valid_r && st1_pass_r;
      wr_ok_s    = wr_req_s && (!fifo_full_s || pop_s);
      lost_s     = wr_req_s && !wr_ok_s;
      occ_next_s = fifo_count_s + CW'(wr_ok_s) - CW'(pop_s);
   end

   sync_fifo_showahead #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_ok_s),
      .din   (st1_entry_r),
      .rd_en (bus.out_ready),
      .dout  (fifo_dout_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s),
      .count (fifo_count_s)
   );

   // Statistics, sticky overflow and the early-warning flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass_count_r  <= 32'd0;
         drop_count_r  <= 32'd0;
         overflow_r    <= 1'b0;
         almost_full_r <= 1'b0;
      end else begin
         pass_count_r  <= pass_count_r + {31'd0, wr_ok_s};
         drop_count_r  <= drop_count_r + {31'd0, (st1_valid_r && !st1_pass_r)};
         overflow_r    <= overflow_r || lost_s;
         almost_full_r <= (occ_next_s >= AF_LEVEL);
      end
   end

   assign pass_count      = pass_count_r;
   assign drop_count      = drop_count_r;
   assign overflow        = overflow_r;
   assign bus.almost_full = almost_full_r;
   assign bus.out_valid   = !fifo_empty_s;
   assign bus.out_r2      = fifo_dout_s[EW-1 -: DATA_WIDTH];
   assign bus.out_dx      = fifo_dout_s[3*DATA_WIDTH+TAG_WIDTH-1 -: DATA_WIDTH];
   assign bus.out_dy      = fifo_dout_s[2*DATA_WIDTH+TAG_WIDTH-1 -: DATA_WIDTH];
   assign bus.out_dz      = fifo_dout_s[DATA_WIDTH+TAG_WIDTH-1 -: DATA_WIDTH];
   assign bus.out_tag     = fifo_dout_s[TAG_WIDTH-1:0];

endmodule

// File: doc/r2_cutoff_filter_buffer.md
Name: r2_cutoff_filter_buffer

Overview:
Sits directly downstream of the r2/displacement stage in the range-limited pipeline. Per valid pair it checks the IEEE-754 single-precision r2 against the cutoff radius squared and rejects self-pairs and invalid values. It buffers accepted pairs (r2, dx, dy, dz, pair tag) in a FIFO that drains to the force-evaluation stage through a valid/ready handshake. The upstream stage cannot stall, so the block asserts almost_full early enough to cover upstream in-flight pairs.

Parameters:
DATA_WIDTH, 32, width of FP values (IEEE-754 single)
TAG_WIDTH, 16, pair tag width (ref/neighbor IDs, carried opaquely)
CUTOFF_2, 32'h41900000, cutoff radius squared (18.0); strictly-less-than test
FIFO_DEPTH, 32, entries; power of two
SLACK, 20, free entries reserved for upstream in-flight pairs (17 upstream + 2 internal + 1 margin)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  pair valid (upstream r2_valid)
in_r2  in  DATA_WIDTH  r2
in_dx  in  DATA_WIDTH  dx
in_dy  in  DATA_WIDTH  dy
in_dz  in  DATA_WIDTH  dz
in_tag  in  TAG_WIDTH  pair tag, aligned with in_valid
almost_full  out  1  upstream must stop issuing new pairs
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_r2, out_dx, out_dy, out_dz  out  DATA_WIDTH each  head entry fields
out_tag  out  TAG_WIDTH  head entry tag
pass_count  out  32  pairs accepted into FIFO, wraps
drop_count  out  32  pairs rejected by filter, wraps
overflow  out  1  sticky; a passing pair was lost because the FIFO was full

Behaviour:
- Reset (rst low, async): FIFO empty; pointers, occupancy, counters at 0; out_valid, almost_full, overflow at 0; out_* data at 0; stage-1 valid at 0. Deassertion takes effect on the next clk edge.
- Stage 1 (edge N, in_valid=1): register data plus pass flag.
- pass = (r2[31]==0) && (r2[30:23]!=8'hFF) && (r2[30:0]!=0) && (r2[30:0] < CUTOFF_2[30:0]). The comparison is unsigned integer on the magnitude bits, which is valid for non-negative floats.
- Drop cases:
  - negative r2, including -0 (sign=1)
  - NaN or Inf
  - +0, which is a self-pair
  - r2 == CUTOFF_2; the boundary value is dropped
- Denormals pass.
- Stage 2 (edge N+1):
  - Stage-1 valid with pass: write the FIFO and increment pass_count.
  - Stage-1 valid without pass: increment drop_count.
- Overflow: a passing pair with the FIFO full and no simultaneous read is discarded. overflow is set and stays set until reset. pass_count does not increment, and drop_count does not increment.
- Simultaneous read and write while full: the write is accepted and occupancy is unchanged.
- Output: show-ahead. out_* are registered from the head entry.
  - Empty-FIFO latency: out_valid rises in the cycle after edge N+1, i.e. 2 cycles after in_valid is sampled.
  - No bypass: a write to an empty FIFO is not visible in the same cycle.
- Handshake:
  - The head is popped on an edge where out_valid && out_ready.
  - out_* stay stable while out_valid=1 and out_ready=0.
  - The next entry appears on the cycle after a pop; full throughput is 1 pair/cycle.
- almost_full = (occupancy >= FIFO_DEPTH - SLACK). Registered, updated every edge.
- Occupancy counter width is log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Counters wrap at 2^32.

Decomposition:
- Shared package:
  - FP field constants: sign bit index, exponent range, exponent all-ones value
  - default CUTOFF_2
  - upstream latency constant (17), used to derive SLACK
- One sub-module: sync_fifo_showahead. Parameterised width/depth; ports wr_en/din, rd_en/dout, empty, full, count. Async active-low reset.
- Filter compare and counters live in the top module.

Test Plan:
1. Reset with pairs in the FIFO and almost_full high: pull rst low mid-stream -> immediately out_valid=0, almost_full=0, counters=0, overflow=0.
2. Basic filter, cutoff 18.0, out_ready=1: r2 = 16.0 (41800000), 18.0 (41900000), 0.0, 80000000, 7FC00000 -> only the 16.0 pair emerges, 2 cycles after input, with its dx/dy/dz/tag intact; pass_count=1, drop_count=4.
3. Backpressure: out_ready=0, then 12 consecutive passing pairs -> occupancy 12, almost_full asserts at 12 (32-20), and out_* hold pair 0. Raise out_ready -> 12 pairs drain in order, one per cycle.
4. Full and overflow: out_ready=0, feed 33 passing pairs -> first 32 stored, overflow=1, pass_count=32, drop_count=0. Then feed 1 pair while out_ready=1 and the FIFO is full -> write accepted, occupancy stays 32.
5. Streaming: continuous in_valid of alternating pass/drop with out_ready toggling randomly -> output sequence equals the passing inputs in order, with no duplicates or losses, and pass_count + drop_count = inputs.
